// File: rtl/data_mem_lsu_if.sv
// Core/memory handshake bundle for data_mem_lsu.
// master: the LSU side (Req_Ready, Rsp_*, Mem_Req/Addr/We/Wdata out); slave: core and memory.
interface data_mem_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  Req_Valid;
    logic                  Req_Ready;
    logic                  Req_Store;
    logic [2:0]            Req_Op;
    logic [ADDR_WIDTH-1:0] Req_Addr;
    logic [DATA_WIDTH-1:0] Req_Wdata;
    logic                  Rsp_Valid;
    logic [DATA_WIDTH-1:0] Rsp_Rdata;
    logic                  Rsp_Fault;
    logic                  Mem_Req;
    logic [ADDR_WIDTH-1:0] Mem_Addr;
    logic [BYTES-1:0]      Mem_We;
    logic [DATA_WIDTH-1:0] Mem_Wdata;
    logic                  Mem_Ack;
    logic [DATA_WIDTH-1:0] Mem_Rdata;

    modport master (
        input  Req_Valid, Req_Store, Req_Op, Req_Addr, Req_Wdata,
        input  Mem_Ack, Mem_Rdata,
        output Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Fault,
        output Mem_Req, Mem_Addr, Mem_We, Mem_Wdata
    );

    modport slave (
        output Req_Valid, Req_Store, Req_Op, Req_Addr, Req_Wdata,
        output Mem_Ack, Mem_Rdata,
        input  Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Fault,
        input  Mem_Req, Mem_Addr, Mem_We, Mem_Wdata
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Multi-cycle load/store unit: core valid/ready in, word memory req/ack out.
// Ports: Clk, Reset_N (async low), bus (data_mem_lsu_if.master). Option: MISALIGNED_SPLIT_EN.
module data_mem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic            Clk,
    input logic            Reset_N,
    data_mem_lsu_if.master bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
`ifdef MISALIGNED_SPLIT_EN
    localparam int LW    = 2 * BYTES;
`else
    localparam int LW    = BYTES;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
`ifdef MISALIGNED_SPLIT_EN
    localparam logic [1:0] S_BEAT1 = 2'd2;
`endif
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            r_state;
    logic [2:0]            r_op;
    logic                  r_store;
    logic [OFF-1:0]        r_off;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BYTES-1:0]      r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_fault;
`ifdef MISALIGNED_SPLIT_EN
    logic                  r_split;
    logic [BYTES-1:0]      r_we1;
    logic [DATA_WIDTH-1:0] r_wd1;
    logic [DATA_WIDTH-1:0] r_word0;
`endif

    logic [OFF-1:0]        w_off;
    logic [15:0]           w_ones;
    logic [2:0]            w_amask;
    logic [LW-1:0]         w_be;
    logic [LW*8-1:0]       w_wd;
    logic [LW*8-1:0]       w_rd;
    logic [DATA_WIDTH-1:0] w_sh;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_misal;
    logic                  w_illegal;

    function automatic logic [63:0] f_ext(input logic [DATA_WIDTH-1:0] w,
                                          input logic [2:0] op);
        logic [63:0] v;
        logic        s;
        v = 64'(w);
        s = ~op[2];
        unique case (op[1:0])
            2'd0:    f_ext = {{56{s & v[7]}}, v[7:0]};
            2'd1:    f_ext = {{48{s & v[15]}}, v[15:0]};
            2'd2:    f_ext = {{32{s & v[31]}}, v[31:0]};
            default: f_ext = v;
        endcase
    endfunction

    assign w_off = bus.Req_Addr[OFF-1:0];

    always_comb begin
        w_ones  = 16'h0001;
        w_amask = 3'd0;
        unique case (bus.Req_Op[1:0])
            2'd0:    begin w_ones = 16'h0001; w_amask = 3'd0; end
            2'd1:    begin w_ones = 16'h0003; w_amask = 3'd1; end
            2'd2:    begin w_ones = 16'h000F; w_amask = 3'd3; end
            default: begin w_ones = 16'h00FF; w_amask = 3'd7; end
        endcase
    end

    // Enables/data laid out over two words; the upper word is the second beat.
    assign w_be    = w_ones[LW-1:0] << w_off;
    assign w_wd    = (LW*8)'(bus.Req_Wdata) << {w_off, 3'b000};
    assign w_misal = |(w_off & w_amask[OFF-1:0]);

    always_comb begin
        w_illegal = (bus.Req_Store && bus.Req_Op[2]) || (bus.Req_Op == 3'b111);
        if (DATA_WIDTH == 32 && (bus.Req_Op == 3'b011 || bus.Req_Op == 3'b110))
            w_illegal = 1'b1;
`ifndef MISALIGNED_SPLIT_EN
        if (w_misal)
            w_illegal = 1'b1;
`endif
    end

`ifdef MISALIGNED_SPLIT_EN
    assign w_rd = (r_state == S_BEAT1) ? {bus.Mem_Rdata, r_word0}
                                       : {{DATA_WIDTH{1'b0}}, bus.Mem_Rdata};
`else
    assign w_rd = bus.Mem_Rdata;
`endif
    assign w_sh   = DATA_WIDTH'(w_rd >> {r_off, 3'b000});
    assign w_load = r_store ? '0 : DATA_WIDTH'(f_ext(w_sh, r_op));

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_store     <= 1'b0;
            r_off       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            r_split     <= 1'b0;
            r_we1       <= '0;
            r_wd1       <= '0;
            r_word0     <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.Req_Valid) begin
                        r_op    <= bus.Req_Op;
                        r_store <= bus.Req_Store;
                        r_off   <= w_off;
                        if (w_illegal) begin
                            r_state     <= S_RESP;
                            r_rsp_fault <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state     <= S_BEAT0;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= {bus.Req_Addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                            r_mem_we    <= bus.Req_Store ? w_be[BYTES-1:0] : '0;
                            r_mem_wdata <= w_wd[DATA_WIDTH-1:0];
`ifdef MISALIGNED_SPLIT_EN
                            r_split     <= |w_be[LW-1:BYTES];
                            r_we1       <= bus.Req_Store ? w_be[LW-1:BYTES] : '0;
                            r_wd1       <= w_wd[LW*8-1:DATA_WIDTH];
`endif
                        end
                    end
                end
                S_BEAT0: begin
                    if (bus.Mem_Ack) begin
`ifdef MISALIGNED_SPLIT_EN
                        if (r_split) begin
                            r_state     <= S_BEAT1;
                            r_word0     <= bus.Mem_Rdata;
                            r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(BYTES);
                            r_mem_we    <= r_we1;
                            r_mem_wdata <= r_wd1;
                        end else
`endif
                        begin
                            r_state     <= S_RESP;
                            r_mem_req   <= 1'b0;
                            r_mem_we    <= '0;
                            r_rsp_fault <= 1'b0;
                            r_rsp_rdata <= w_load;
                        end
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                S_BEAT1: begin
                    if (bus.Mem_Ack) begin
                        r_state     <= S_RESP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= '0;
                        r_rsp_fault <= 1'b0;
                        r_rsp_rdata <= w_load;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Req_Ready = (r_state == S_IDLE);
    assign bus.Rsp_Valid = (r_state == S_RESP);
    assign bus.Rsp_Rdata = r_rsp_rdata;
    assign bus.Rsp_Fault = r_rsp_fault;
    assign bus.Mem_Req   = r_mem_req;
    assign bus.Mem_Addr  = r_mem_addr;
    assign bus.Mem_We    = r_mem_we;
    assign bus.Mem_Wdata = r_mem_wdata;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu (DATA_WIDTH=32, ADDR_WIDTH=12).
// Follows MISALIGNED_SPLIT_EN the same way the design does.
module tb_data_mem_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .Clk     (clk),
        .Reset_N (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [0:1023];
    int wait0 = 0, wait1 = 0;
    int wcnt = 0, beat_idx = 0, req_cycles = 0;
    logic [11:0] lg_addr [0:3];
    logic [3:0]  lg_we   [0:3];
    logic [31:0] lg_wd   [0:3];

    // Memory responder: ack after the configured wait count per beat.
    always @(negedge clk) begin
        int w;
        bus.Mem_Ack = 1'b0;
        w = (beat_idx == 0) ? wait0 : wait1;
        if (bus.Mem_Req === 1'b1) begin
            if (wcnt >= w) begin
                bus.Mem_Ack   = 1'b1;
                bus.Mem_Rdata = mem[bus.Mem_Addr[11:2]];
                if (beat_idx < 4) begin
                    lg_addr[beat_idx] = bus.Mem_Addr;
                    lg_we[beat_idx]   = bus.Mem_We;
                    lg_wd[beat_idx]   = bus.Mem_Wdata;
                end
                for (int b = 0; b < 4; b++)
                    if (bus.Mem_We[b])
                        mem[bus.Mem_Addr[11:2]][8*b +: 8] = bus.Mem_Wdata[8*b +: 8];
                beat_idx++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(posedge clk) if (bus.Mem_Req === 1'b1) req_cycles++;

    task automatic do_req(input logic st, input logic [2:0] op,
                          input logic [11:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic flt, output logic rdy1,
                          output logic rdy_after);
        @(negedge clk);
        beat_idx = 0;
        req_cycles = 0;
        bus.Req_Valid = 1'b1;
        bus.Req_Store = st;
        bus.Req_Op    = op;
        bus.Req_Addr  = addr;
        bus.Req_Wdata = wd;
        @(posedge clk);
        #1 bus.Req_Valid = 1'b0;
        lat = -1; rd = 'x; flt = 1'bx; rdy1 = 1'bx; rdy_after = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) rdy1 = bus.Req_Ready;
            if (bus.Rsp_Valid === 1'b1) begin
                lat = k;
                rd  = bus.Rsp_Rdata;
                flt = bus.Rsp_Fault;
                break;
            end
        end
        @(negedge clk);
        rdy_after = bus.Req_Ready;
    endtask

    int lat;
    logic [31:0] rd;
    logic flt, r1, ra;

    task automatic test_reset();
        n_chk++;
        if (bus.Req_Ready !== 1'b1 || bus.Rsp_Valid !== 1'b0 || bus.Rsp_Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl ready=%b valid=%b fault=%b want 1 0 0",
                     bus.Req_Ready, bus.Rsp_Valid, bus.Rsp_Fault);
        end
        n_chk++;
        if (bus.Rsp_Rdata !== 32'h0 || bus.Mem_Req !== 1'b0 || bus.Mem_Addr !== 12'h0 ||
            bus.Mem_We !== 4'h0 || bus.Mem_Wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data rdata=%h req=%b addr=%h we=%b wd=%h want all 0",
                     bus.Rsp_Rdata, bus.Mem_Req, bus.Mem_Addr, bus.Mem_We, bus.Mem_Wdata);
        end
    endtask

    task automatic test_lw();
        do_req(1'b0, 3'b010, 12'h100, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (lat !== 2 || rd !== 32'h44332211 || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL lw lat=%0d rd=%h flt=%b want 2 44332211 0", lat, rd, flt);
        end
        n_chk++;
        if (beat_idx !== 1 || lg_addr[0] !== 12'h100 || lg_we[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL lw_beat n=%0d addr=%h we=%b want 1 100 0000",
                     beat_idx, lg_addr[0], lg_we[0]);
        end
        n_chk++;
        if (r1 !== 1'b0 || ra !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_ready t1=%b after=%b want 0 1", r1, ra);
        end
    endtask

    task automatic test_split_load();
        do_req(1'b0, 3'b001, 12'h103, 32'h0, lat, rd, flt, r1, ra);
`ifdef MISALIGNED_SPLIT_EN
        n_chk++;
        if (lat !== 3 || rd !== 32'h00005544 || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL lh_split lat=%0d rd=%h flt=%b want 3 00005544 0", lat, rd, flt);
        end
        n_chk++;
        if (beat_idx !== 2 || lg_addr[0] !== 12'h100 || lg_addr[1] !== 12'h104) begin
            n_fail++;
            $display("FAIL lh_split_beats n=%0d a0=%h a1=%h want 2 100 104",
                     beat_idx, lg_addr[0], lg_addr[1]);
        end
`else
        n_chk++;
        if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0 || req_cycles !== 0) begin
            n_fail++;
            $display("FAIL lh_misal lat=%0d flt=%b rd=%h reqcyc=%0d want 1 1 0 0",
                     lat, flt, rd, req_cycles);
        end
`endif
    endtask

    task automatic test_ext();
        do_req(1'b0, 3'b000, 12'h107, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (lat !== 2 || rd !== 32'hFFFFFF88 || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL lb lat=%0d rd=%h flt=%b want 2 ffffff88 0", lat, rd, flt);
        end
        do_req(1'b0, 3'b100, 12'h107, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (lat !== 2 || rd !== 32'h00000088) begin
            n_fail++;
            $display("FAIL lbu lat=%0d rd=%h want 2 00000088", lat, rd);
        end
        do_req(1'b0, 3'b001, 12'h106, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (rd !== 32'hFFFF8877) begin
            n_fail++;
            $display("FAIL lh rd=%h want ffff8877", rd);
        end
        do_req(1'b0, 3'b101, 12'h106, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (rd !== 32'h00008877) begin
            n_fail++;
            $display("FAIL lhu rd=%h want 00008877", rd);
        end
    endtask

    task automatic test_sb();
        do_req(1'b1, 3'b000, 12'h101, 32'h000000AB, lat, rd, flt, r1, ra);
        n_chk++;
        if (beat_idx !== 1 || lg_we[0] !== 4'b0010 || lg_wd[0] !== 32'h0000AB00 ||
            lg_addr[0] !== 12'h100) begin
            n_fail++;
            $display("FAIL sb_beat n=%0d addr=%h we=%b wd=%h want 1 100 0010 0000ab00",
                     beat_idx, lg_addr[0], lg_we[0], lg_wd[0]);
        end
        n_chk++;
        if (lat !== 2 || rd !== 32'h0 || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_rsp lat=%0d rd=%h flt=%b want 2 0 0", lat, rd, flt);
        end
        do_req(1'b0, 3'b010, 12'h100, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (rd !== 32'h4433AB11) begin
            n_fail++;
            $display("FAIL sb_readback rd=%h want 4433ab11", rd);
        end
    endtask

    task automatic test_split_store();
        wait0 = 3;
        do_req(1'b1, 3'b010, 12'hFFE, 32'hDDCCBBAA, lat, rd, flt, r1, ra);
        wait0 = 0;
`ifdef MISALIGNED_SPLIT_EN
        n_chk++;
        if (lat !== 6 || flt !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_wrap_rsp lat=%0d flt=%b rd=%h want 6 0 0", lat, flt, rd);
        end
        n_chk++;
        if (beat_idx !== 2 || lg_addr[0] !== 12'hFFC || lg_we[0] !== 4'b1100 ||
            lg_wd[0] !== 32'hBBAA0000) begin
            n_fail++;
            $display("FAIL sw_wrap_b0 n=%0d addr=%h we=%b wd=%h want 2 ffc 1100 bbaa0000",
                     beat_idx, lg_addr[0], lg_we[0], lg_wd[0]);
        end
        n_chk++;
        if (lg_addr[1] !== 12'h000 || lg_we[1] !== 4'b0011 || lg_wd[1] !== 32'h0000DDCC) begin
            n_fail++;
            $display("FAIL sw_wrap_b1 addr=%h we=%b wd=%h want 000 0011 0000ddcc",
                     lg_addr[1], lg_we[1], lg_wd[1]);
        end
`else
        n_chk++;
        if (lat !== 1 || flt !== 1'b1 || req_cycles !== 0) begin
            n_fail++;
            $display("FAIL sw_misal lat=%0d flt=%b reqcyc=%0d want 1 1 0", lat, flt, req_cycles);
        end
`endif
    endtask

    task automatic test_faults();
        logic [2:0] ops [3];
        logic       sts [3];
        ops[0] = 3'b100; sts[0] = 1'b1;
        ops[1] = 3'b011; sts[1] = 1'b0;
        ops[2] = 3'b111; sts[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_req(sts[i], ops[i], 12'h100, 32'h12345678, lat, rd, flt, r1, ra);
            n_chk++;
            if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0 || req_cycles !== 0 || ra !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_%0d lat=%0d flt=%b rd=%h reqcyc=%0d rdy=%b want 1 1 0 0 1",
                         i, lat, flt, rd, req_cycles, ra);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hold;
        do_req(1'b0, 3'b010, 12'h104, 32'h0, lat, rd, flt, r1, ra);
        do_req(1'b0, 3'b000, 12'h100, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (lat !== 2 || rd !== 32'h00000011) begin
            n_fail++;
            $display("FAIL b2b lat=%0d rd=%h want 2 00000011", lat, rd);
        end
        hold = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.Rsp_Rdata !== 32'h00000011 || bus.Rsp_Valid !== 1'b0) hold++;
        end
        n_chk++;
        if (hold !== 0) begin
            n_fail++;
            $display("FAIL rsp_hold bad_cycles=%0d want 0", hold);
        end
    endtask

    task automatic test_reset_mid_beat();
        int found, rsp;
        found = 0;
        rsp = 0;
        @(negedge clk);
        beat_idx = 0;
`ifdef MISALIGNED_SPLIT_EN
        wait1 = 20;
        bus.Req_Store = 1'b1; bus.Req_Op = 3'b010;
        bus.Req_Addr = 12'hFFE; bus.Req_Wdata = 32'hDDCCBBAA;
`else
        wait0 = 20;
        bus.Req_Store = 1'b0; bus.Req_Op = 3'b010;
        bus.Req_Addr = 12'h100; bus.Req_Wdata = 32'h0;
`endif
        bus.Req_Valid = 1'b1;
        @(posedge clk);
        #1 bus.Req_Valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
            if (bus.Mem_Req === 1'b1 && bus.Mem_Addr === 12'h000) begin found = 1; break; end
`else
            if (bus.Mem_Req === 1'b1 && bus.Mem_Addr === 12'h100) begin found = 1; break; end
`endif
        end
        n_chk++;
        if (found !== 1) begin
            n_fail++;
            $display("FAIL rst_mid_reach found=%0d want 1", found);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.Mem_Req !== 1'b0 || bus.Req_Ready !== 1'b1 || bus.Rsp_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid req=%b ready=%b valid=%b want 0 1 0",
                     bus.Mem_Req, bus.Req_Ready, bus.Rsp_Valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait0 = 0;
        wait1 = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.Rsp_Valid !== 1'b0) rsp++;
        end
        n_chk++;
        if (rsp !== 0) begin
            n_fail++;
            $display("FAIL rst_no_rsp count=%0d want 0", rsp);
        end
        do_req(1'b0, 3'b010, 12'h104, 32'h0, lat, rd, flt, r1, ra);
        n_chk++;
        if (lat !== 2 || rd !== 32'h88776655 || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_then_lw lat=%0d rd=%h flt=%b want 2 88776655 0", lat, rd, flt);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[12'h100 >> 2] = 32'h44332211;
        mem[12'h104 >> 2] = 32'h88776655;
        bus.Req_Valid = 1'b0;
        bus.Req_Store = 1'b0;
        bus.Req_Op    = 3'b000;
        bus.Req_Addr  = '0;
        bus.Req_Wdata = '0;
        bus.Mem_Ack   = 1'b0;
        bus.Mem_Rdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_lw();
        test_split_load();
        test_ext();
        test_sb();
        test_split_store();
        test_faults();
        test_back_to_back();
        test_reset_mid_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
